// File: rtl/rect_wave_gen.sv
// rect_wave_gen: periodic trapezoidal-pulse sample generator.
// The sequence is delay, rise ramp, high plateau, fall ramp, low. It advances one sample per
// tick, and the phase timing is loaded over a valid/ready handshake while idle.
// Optional burst mode (finite number of periods, `done` pulse) is enabled by the
// RECT_GEN_BURST_EN macro; without it the generator runs until `en` drops.
module rect_wave_gen #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          tick,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_amp,
  input  logic [W-1:0]  cfg_inc,
  input  logic [W-1:0]  cfg_dec,
  input  logic [CW-1:0] cfg_td,
  input  logic [CW-1:0] cfg_tr,
  input  logic [CW-1:0] cfg_th,
  input  logic [CW-1:0] cfg_tf,
  input  logic [CW-1:0] cfg_tl,
`ifdef RECT_GEN_BURST_EN
  input  logic [CW-1:0] cfg_burst,
  output logic          done,
`endif
  output logic [W-1:0]  out_data,
  output logic          out_strobe,
  output logic          busy
);

  typedef enum logic [2:0] {StIdle, StDelay, StRise, StHigh, StFall, StLow} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;   // ticks already spent in the current phase

  // Shadow configuration, only written while idle
  logic [W-1:0]  amp_q, inc_q, dec_q;
  logic [CW-1:0] td_q, tr_q, th_q, tf_q, tl_q;

  logic [CW-1:0] th_eff;
  logic [CW-1:0] cur_len;
  logic          stay;
  logic          found;
  state_e        probe;
  state_e        nxt_phase;
  state_e        sel_phase;
  logic [CW-1:0] sel_k;
  logic [W-1:0]  base_rise, base_fall;
  logic [W:0]    rise_sum, fall_diff;
  logic [W-1:0]  sample;

  // An all-zero period would never produce a sample, so the plateau gets one tick
  assign th_eff = ((tr_q | th_q | tf_q | tl_q) == '0) ? CW'(1) : th_q;

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  function automatic state_e succ(input state_e s);
    case (s)
      StIdle:  succ = StDelay;
      StDelay: succ = StRise;
      StRise:  succ = StHigh;
      StHigh:  succ = StFall;
      StFall:  succ = StLow;
      default: succ = StRise;  // delay happens only once per start
    endcase
  endfunction

  function automatic logic [CW-1:0] len_of(input state_e s);
    case (s)
      StDelay: len_of = td_q;
      StRise:  len_of = tr_q;
      StHigh:  len_of = th_eff;
      StFall:  len_of = tf_q;
      StLow:   len_of = tl_q;
      default: len_of = '0;
    endcase
  endfunction

  // Pick the phase and in-phase index for the next tick, then the sample value
  always_comb begin
    cur_len   = len_of(state_q);
    stay      = (state_q != StIdle) && (cnt_q < cur_len);
    nxt_phase = StHigh;
    found     = 1'b0;
    probe     = state_q;
    // Zero-length phases are skipped within the same tick
    for (int i = 0; i < 5; i++) begin
      probe = succ(probe);
      if (!found && (len_of(probe) != '0)) begin
        nxt_phase = probe;
        found     = 1'b1;
      end
    end
    sel_phase = stay ? state_q : nxt_phase;
    sel_k     = stay ? (cnt_q + 1'b1) : CW'(1);

    // Ramps accumulate from the previous sample, which equals min(k*inc, amp) /
    // max(amp - k*dec, 0) because every earlier value was already clamped.
    base_rise = (sel_k == CW'(1)) ? '0 : out_data;
    base_fall = (sel_k == CW'(1)) ? amp_q : out_data;
    rise_sum  = {1'b0, base_rise} + {1'b0, inc_q};
    fall_diff = {1'b0, base_fall} - {1'b0, dec_q};

    sample = '0;
    case (sel_phase)
      StRise: begin
        if ((sel_k == tr_q) || (rise_sum > {1'b0, amp_q})) sample = amp_q;
        else                                                  sample = rise_sum[W-1:0];
      end
      StHigh: sample = amp_q;
      StFall: begin
        // fall_diff[W] is the borrow: the decrement went below zero
        if ((sel_k == tf_q) || fall_diff[W]) sample = '0;
        else                                 sample = fall_diff[W-1:0];
      end
      default: sample = '0;
    endcase
  end

`ifdef RECT_GEN_BURST_EN
  logic [CW-1:0] burst_q;
  logic [CW-1:0] periods_q;
  logic [CW-1:0] periods_nxt;
  logic [CW-1:0] sel_len;
  logic          tail_zero;
  logic          period_end;
  logic          burst_last;

  // A period ends on the last tick of the last non-empty phase of rise..low
  always_comb begin
    sel_len = len_of(sel_phase);
    case (sel_phase)
      StRise:  tail_zero = (th_eff == '0) && (tf_q == '0) && (tl_q == '0);
      StHigh:  tail_zero = (tf_q == '0) && (tl_q == '0);
      StFall:  tail_zero = (tl_q == '0);
      StLow:   tail_zero = 1'b1;
      default: tail_zero = 1'b0;
    endcase
    period_end  = (sel_k == sel_len) && tail_zero;
    periods_nxt = ((state_q == StIdle) ? '0 : periods_q) + 1'b1;
    burst_last  = period_end && (burst_q != '0) && (periods_nxt == burst_q);
  end
`endif

  // Main FSM: config capture, phase sequencing and registered sample output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      out_data   <= '0;
      out_strobe <= 1'b0;
      amp_q      <= '0;
      inc_q      <= '0;
      dec_q      <= '0;
      td_q       <= '0;
      tr_q       <= '0;
      th_q       <= '0;
      tf_q       <= '0;
      tl_q       <= '0;
`ifdef RECT_GEN_BURST_EN
      burst_q    <= '0;
      periods_q  <= '0;
      done       <= 1'b0;
`endif
    end else begin
      out_strobe <= 1'b0;
`ifdef RECT_GEN_BURST_EN
      done       <= 1'b0;
`endif
      if ((state_q != StIdle) && !en) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        out_data   <= '0;
        out_strobe <= tick;
      end else if ((state_q == StIdle) && cfg_valid) begin
        // Handshake wins over a coinciding start; the start waits for the next tick
        amp_q <= cfg_amp;
        inc_q <= cfg_inc;
        dec_q <= cfg_dec;
        td_q  <= cfg_td;
        tr_q  <= cfg_tr;
        th_q  <= cfg_th;
        tf_q  <= cfg_tf;
        tl_q  <= cfg_tl;
`ifdef RECT_GEN_BURST_EN
        burst_q <= cfg_burst;
`endif
      end else if (en && tick) begin
        state_q    <= sel_phase;
        cnt_q      <= sel_k;
        out_data   <= sample;
        out_strobe <= 1'b1;
`ifdef RECT_GEN_BURST_EN
        if (state_q == StIdle)              periods_q <= '0;
        if (period_end && (burst_q != '0)) periods_q <= periods_nxt;
        if (burst_last) begin
          state_q <= StIdle;
          cnt_q   <= '0;
          done    <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_rect_wave_gen.sv
// tb_rect_wave_gen: directed stimulus for rect_wave_gen with a per-cycle reference model
// derived from the phase/period arithmetic, plus literal expected sample sequences.
module tb_rect_wave_gen;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          en        = 1'b0;
  logic          tick      = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_amp   = '0;
  logic [W-1:0]  cfg_inc   = '0;
  logic [W-1:0]  cfg_dec   = '0;
  logic [CW-1:0] cfg_td    = '0;
  logic [CW-1:0] cfg_tr    = '0;
  logic [CW-1:0] cfg_th    = '0;
  logic [CW-1:0] cfg_tf    = '0;
  logic [CW-1:0] cfg_tl    = '0;
  logic [W-1:0]  out_data;
  logic          out_strobe;
  logic          busy;
`ifdef RECT_GEN_BURST_EN
  logic [CW-1:0] cfg_burst = '0;
  logic          done;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;
  int cap[$];

  // Reference model state
  int     m_run = 0;
  int     m_t   = 0;
  longint m_amp, m_inc, m_dec, m_td, m_tr, m_th, m_tf, m_tl, m_burst;
  int     exp_data   = 0;
  int     exp_strobe = 0;
  int     exp_done   = 0;

  int e2 [16] = '{0, 0, 25, 50, 75, 100, 100, 100, 100, 75, 50, 25, 0, 0, 0, 25};
  int e3 [9]  = '{30, 60, 100, 100, 40, 0, 0, 0, 30};
  int e5 [11] = '{0, 50, 100, 150, 200, 200, 200, 100, 0, 0, 50};
  int ez [4]  = '{0, 7, 7, 7};

  rect_wave_gen #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_amp    (cfg_amp),
    .cfg_inc    (cfg_inc),
    .cfg_dec    (cfg_dec),
    .cfg_td     (cfg_td),
    .cfg_tr     (cfg_tr),
    .cfg_th     (cfg_th),
    .cfg_tf     (cfg_tf),
    .cfg_tl     (cfg_tl),
`ifdef RECT_GEN_BURST_EN
    .cfg_burst  (cfg_burst),
    .done       (done),
`endif
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    else n_pass++;
  endtask

  function automatic longint per_len();
    longint thx;
    thx = (m_tr + m_th + m_tf + m_tl == 0) ? 1 : m_th;
    return m_tr + thx + m_tf + m_tl;
  endfunction

  // Sample for the t-th tick after start (t = 0 is the starting tick)
  function automatic int model_sample(input int t);
    longint p, k, v, thx;
    thx = (m_tr + m_th + m_tf + m_tl == 0) ? 1 : m_th;
    if (t < m_td) return 0;
    p = (t - m_td) % per_len();
    if (p < m_tr) begin
      k = p + 1;
      if (k == m_tr) return int'(m_amp);
      v = k * m_inc;
      return int'((v > m_amp) ? m_amp : v);
    end
    p = p - m_tr;
    if (p < thx) return int'(m_amp);
    p = p - thx;
    if (p < m_tf) begin
      k = p + 1;
      if (k == m_tf) return 0;
      v = m_amp - k * m_dec;
      return int'((v < 0) ? 0 : v);
    end
    return 0;
  endfunction

  // Number of periods completed if tick t closes a period, else 0
  function automatic longint model_periods(input int t);
    if (t < m_td) return 0;
    if (((t - m_td) % per_len()) != per_len() - 1) return 0;
    return (t - m_td) / per_len() + 1;
  endfunction

  task automatic model_emit();
    exp_data   = model_sample(m_t);
    exp_strobe = 1;
    if (m_burst != 0 && model_periods(m_t) == m_burst) begin
      m_run    = 0;
      exp_done = 1;
    end
  endtask

  // Reference model, evaluated on each rising edge from the inputs held since the falling edge
  initial begin
    forever begin
      @(posedge clk);
      exp_strobe = 0;
      exp_done   = 0;
      if (!rst_n) begin
        m_run = 0; m_t = 0; exp_data = 0;
        m_amp = 0; m_inc = 0; m_dec = 0; m_td = 0; m_tr = 0; m_th = 0; m_tf = 0; m_tl = 0;
        m_burst = 0;
      end else if (m_run == 0) begin
        if (cfg_valid) begin
          m_amp = cfg_amp; m_inc = cfg_inc; m_dec = cfg_dec;
          m_td = cfg_td; m_tr = cfg_tr; m_th = cfg_th; m_tf = cfg_tf; m_tl = cfg_tl;
`ifdef RECT_GEN_BURST_EN
          m_burst = cfg_burst;
`endif
        end else if (en && tick) begin
          m_run = 1;
          m_t   = 0;
          model_emit();
        end
      end else if (!en) begin
        m_run      = 0;
        exp_data   = 0;
        exp_strobe = tick ? 1 : 0;
      end else if (tick) begin
        m_t++;
        model_emit();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("strobe", 32'(out_strobe), 32'(exp_strobe));
        chk("data", 32'(out_data), 32'(exp_data));
        chk("busy", 32'(busy), 32'(m_run != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_run == 0));
`ifdef RECT_GEN_BURST_EN
        chk("done", 32'(done), 32'(exp_done));
`endif
        if (out_strobe === 1'b1) cap.push_back(int'(out_data));
      end
    end
  end

  task automatic set_cfg(input int amp, input int inc, input int dec, input int td,
                         input int tr, input int th, input int tf, input int tl,
                         input int burst);
    cfg_amp = amp[W-1:0];
    cfg_inc = inc[W-1:0];
    cfg_dec = dec[W-1:0];
    cfg_td  = td[CW-1:0];
    cfg_tr  = tr[CW-1:0];
    cfg_th  = th[CW-1:0];
    cfg_tf  = tf[CW-1:0];
    cfg_tl  = tl[CW-1:0];
`ifdef RECT_GEN_BURST_EN
    cfg_burst = burst[CW-1:0];
`else
    if (burst != 0) $display("note: burst count ignored in this build");
`endif
  endtask

  task automatic load(input int amp, input int inc, input int dec, input int td, input int tr,
                      input int th, input int tf, input int tl, input int burst);
    int g;
    g = 0;
    while (cfg_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("load_ready", 32'(cfg_ready), 32'd1);
    set_cfg(amp, inc, dec, td, tr, th, tf, tl, burst);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run(input int n, input int every);
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick = ((i % every) == 0);
      @(negedge clk);
    end
  endtask

  task automatic stop();
    en   = 1'b0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_strobe", 32'(out_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick = i[0];
      @(negedge clk);
      chk("idle_ready", 32'(cfg_ready), 32'd1);
      chk("idle_data", 32'(out_data), 32'd0);
    end
    tick = 1'b0;

    // Full trapezoid, tick every cycle
    load(100, 25, 25, 2, 4, 3, 4, 2, 0);
    cap.delete();
    run(20, 1);
    stop();
    chk("c2_count", 32'(cap.size()), 32'd20);
    for (int i = 0; i < 16; i++) chk($sformatf("c2_s%0d", i), 32'(cap[i]), 32'(e2[i]));

    // Clamped rise, saturated then forced fall
    load(100, 30, 60, 0, 3, 1, 3, 1, 0);
    cap.delete();
    run(9, 1);
    stop();
    for (int i = 0; i < 9; i++) chk($sformatf("c3_s%0d", i), 32'(cap[i]), 32'(e3[i]));

    // Skipped phases, sparse ticks
    load(100, 25, 25, 0, 0, 1, 0, 1, 0);
    cap.delete();
    run(18, 3);
    stop();
    chk("c4_count", 32'(cap.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("c4_s%0d", i), 32'(cap[i]), (i % 2 == 0) ? 32'd100 : 32'd0);

    // Empty period: plateau of one tick after the delay
    load(7, 0, 0, 1, 0, 0, 0, 0, 0);
    cap.delete();
    run(4, 1);
    stop();
    for (int i = 0; i < 4; i++) chk($sformatf("cz_s%0d", i), 32'(cap[i]), 32'(ez[i]));

    // Enable dropped during the plateau, then reconfigure with a coinciding start tick
    load(100, 25, 25, 2, 4, 3, 4, 2, 0);
    run(7, 1);
    en   = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    chk("drop_data", 32'(out_data), 32'd0);
    chk("drop_strobe", 32'(out_strobe), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_ready", 32'(cfg_ready), 32'd1);
    set_cfg(200, 50, 100, 1, 4, 2, 2, 1, 0);
    cfg_valid = 1'b1;
    en        = 1'b1;
    tick      = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_strobe", 32'(out_strobe), 32'd0);
    cap.delete();
    run(11, 1);
    stop();
    for (int i = 0; i < 11; i++) chk($sformatf("c5_s%0d", i), 32'(cap[i]), 32'(e5[i]));

    // Reset in the middle of a ramp
    load(100, 30, 60, 0, 3, 1, 3, 1, 0);
    run(2, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_strobe", 32'(out_strobe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    stop();

`ifdef RECT_GEN_BURST_EN
    begin
      int seen;
      seen = 0;
      load(100, 25, 25, 2, 4, 3, 4, 2, 2);
      cap.delete();
      en   = 1'b1;
      tick = 1'b1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          seen = 1;
          en   = 1'b0;
          tick = 1'b0;
          break;
        end
      end
      chk("burst_done_seen", 32'(seen), 32'd1);
      stop();
      chk("burst_count", 32'(cap.size()), 32'd28);
      chk("burst_last", 32'(cap[cap.size() - 1]), 32'd0);
      chk("burst_idle", 32'(busy), 32'd0);
    end
`endif

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
